addsub_serial: RTL and testbench

ADDSUB_SERIAL -- requirements
Module: addsub_serial

---
 rtl/addsub_serial.sv | 132 +++++++++++++
 tb/tb_addsub_serial.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_serial.sv
// rtl/addsub_serial.sv - chunk-serial adder/subtractor with carry, overflow, zero and sign flags
//
// Adds a + b + cin (op=0) or a + ~b + cin (op=1) CHUNK bits per cycle. An
// accepted request takes exactly NCH = WIDTH/CHUNK cycles, and done pulses on
// the last of them. result and the flags change only at completion.
//
// Ports:
//   clk     - clock, rising edge
//   rst_n   - asynchronous active-low reset
//   start   - request, taken only while busy=0
//   op      - 0 = add, 1 = subtract (b is inverted)
//   a, b    - operands, WIDTH bits
//   cin     - carry-in (set to 1 with op=1 for a true a-b)
//   busy    - operation in progress
//   done    - one-cycle completion pulse
//   result  - sum/difference, held until the next completion
//   cout    - carry out of bit WIDTH-1
//   ovf     - signed overflow
//   zero    - result is all zeros
//   neg     - result[WIDTH-1]

module addsub_serial #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);

    localparam int NCH = WIDTH / CHUNK;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CW-1:0]     cnt;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic              carry_q;
    logic [WIDTH-1:0]  shadow;
    logic [WIDTH-1:0]  shadow_next;
    logic [CHUNK-1:0]  a_ch;
    logic [CHUNK-1:0]  b_ch;
    logic [CHUNK:0]    ch_sum;
    logic              msb_cin;
    logic              last;
    int unsigned       base;

    // Datapath for the chunk currently selected by cnt.
    always_comb begin
        base        = int'(cnt) * CHUNK;
        a_ch        = a_q[base +: CHUNK];
        b_ch        = b_q[base +: CHUNK];
        ch_sum      = {1'b0, a_ch} + {1'b0, b_ch} + {{CHUNK{1'b0}}, carry_q};
        // Carry into the chunk MSB recovered from the sum bit; only meaningful
        // on the last chunk, where it is the carry into bit WIDTH-1.
        msb_cin     = a_ch[CHUNK-1] ^ b_ch[CHUNK-1] ^ ch_sum[CHUNK-1];
        shadow_next = shadow;
        shadow_next[base +: CHUNK] = ch_sum[CHUNK-1:0];
        last        = (cnt == CW'(NCH - 1));
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_RUN;
            S_RUN:   if (last)  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    assign busy = (state == S_RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            shadow  <= '0;
            done    <= 1'b0;
            result  <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
            zero    <= 1'b1;
            neg     <= 1'b0;
        end else begin
            state <= state_next;
            done  <= 1'b0;
            if (state == S_IDLE) begin
                if (start) begin
                    a_q     <= a;
                    b_q     <= op ? ~b : b;
                    carry_q <= cin;
                    cnt     <= '0;
                end
            end else begin
                shadow  <= shadow_next;
                carry_q <= ch_sum[CHUNK];
                if (last) begin
                    cnt    <= '0;
                    done   <= 1'b1;
                    result <= shadow_next;
                    cout   <= ch_sum[CHUNK];
                    ovf    <= msb_cin ^ ch_sum[CHUNK];
                    zero   <= (shadow_next == '0);
                    neg    <= shadow_next[WIDTH-1];
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_addsub_serial.sv
// tb/tb_addsub_serial.sv - scoreboard bench for addsub_serial at CHUNK=8, 1 and 32

module tb_addsub_serial;

    typedef struct {
        int          dut;
        logic [31:0] res;
        logic        cout;
        logic        ovf;
        logic        zero;
        logic        neg;
        int          done_cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        op = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        cin = 1'b0;
    logic        start_v [3];
    logic        busy_v  [3];
    logic        done_v  [3];
    logic [31:0] res_v   [3];
    logic        cout_v  [3];
    logic        ovf_v   [3];
    logic        zero_v  [3];
    logic        neg_v   [3];

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   lat [3] = '{4, 32, 1};
    exp_t sb [$];
    exp_t last_exp;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    addsub_serial #(.WIDTH(32), .CHUNK(8)) u_c8 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .op(op), .a(a), .b(b), .cin(cin),
        .busy(busy_v[0]), .done(done_v[0]), .result(res_v[0]), .cout(cout_v[0]),
        .ovf(ovf_v[0]), .zero(zero_v[0]), .neg(neg_v[0]));

    addsub_serial #(.WIDTH(32), .CHUNK(1)) u_c1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .op(op), .a(a), .b(b), .cin(cin),
        .busy(busy_v[1]), .done(done_v[1]), .result(res_v[1]), .cout(cout_v[1]),
        .ovf(ovf_v[1]), .zero(zero_v[1]), .neg(neg_v[1]));

    addsub_serial #(.WIDTH(32), .CHUNK(32)) u_c32 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .op(op), .a(a), .b(b), .cin(cin),
        .busy(busy_v[2]), .done(done_v[2]), .result(res_v[2]), .cout(cout_v[2]),
        .ovf(ovf_v[2]), .zero(zero_v[2]), .neg(neg_v[2]));

    // Reference: 33-bit add on the effective operand; overflow from operand/result signs.
    function automatic exp_t model(int d, logic o, logic [31:0] x, logic [31:0] y, logic c, int acc);
        exp_t        e;
        logic [31:0] yy;
        logic [32:0] s;
        yy         = o ? ~y : y;
        s          = {1'b0, x} + {1'b0, yy} + {32'd0, c};
        e.dut      = d;
        e.res      = s[31:0];
        e.cout     = s[32];
        e.ovf      = (x[31] == yy[31]) && (s[31] != x[31]);
        e.zero     = (s[31:0] == 32'd0);
        e.neg      = s[31];
        e.done_cyc = acc + lat[d];
        return e;
    endfunction

    // Completion monitor: every done must match the oldest expectation, on time.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (done_v[d] === 1'b1) begin
                exp_t e;
                checks++;
                if (sb.size() == 0 || sb[0].dut != d) begin
                    errors++;
                    $display("FAIL unexpected_done dut=%0d cyc=%0d got done=1 want no done", d, cyc);
                end else begin
                    e = sb.pop_front();
                    last_exp = e;
                    if (res_v[d] !== e.res || cout_v[d] !== e.cout || ovf_v[d] !== e.ovf ||
                        zero_v[d] !== e.zero || neg_v[d] !== e.neg) begin
                        errors++;
                        $display("FAIL result dut=%0d got %h c%b v%b z%b n%b want %h c%b v%b z%b n%b",
                                 d, res_v[d], cout_v[d], ovf_v[d], zero_v[d], neg_v[d],
                                 e.res, e.cout, e.ovf, e.zero, e.neg);
                    end
                    checks++;
                    if (cyc != e.done_cyc) begin
                        errors++;
                        $display("FAIL latency dut=%0d got cyc %0d want cyc %0d", d, cyc, e.done_cyc);
                    end
                end
            end
        end
    end

    task automatic issue(int d, logic o, logic [31:0] x, logic [31:0] y, logic c);
        @(negedge clk);
        op = o; a = x; b = y; cin = c;
        start_v[d] = 1'b1;
        @(posedge clk);
        #1;
        start_v[d] = 1'b0;
        checks++;
        if (busy_v[d] !== 1'b1) begin
            errors++;
            $display("FAIL accept dut=%0d got busy=%b want 1", d, busy_v[d]);
        end
        sb.push_back(model(d, o, x, y, c, cyc));
    endtask

    task automatic wait_done();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL timeout got %0d pending want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        start_v[0] = 1'b1;
        op = 1'b0; a = 32'h0000_0003; b = 32'h0000_0004; cin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (busy_v[d] !== 1'b0 || done_v[d] !== 1'b0 || res_v[d] !== 32'd0 || cout_v[d] !== 1'b0 ||
                ovf_v[d] !== 1'b0 || zero_v[d] !== 1'b1 || neg_v[d] !== 1'b0) begin
                errors++;
                $display("FAIL reset_state dut=%0d got b%b d%b r%h c%b v%b z%b n%b want b0 d0 r0 c0 v0 z1 n0",
                         d, busy_v[d], done_v[d], res_v[d], cout_v[d], ovf_v[d], zero_v[d], neg_v[d]);
            end
        end
        // start held through reset is taken at the first edge after release.
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        checks++;
        if (busy_v[0] !== 1'b1) begin
            errors++;
            $display("FAIL first_accept got busy=%b want 1", busy_v[0]);
        end
        sb.push_back(model(0, 1'b0, 32'h0000_0003, 32'h0000_0004, 1'b0, cyc));
        wait_done();
    endtask

    task automatic test_vectors(int d);
        issue(d, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0); wait_done();
        issue(d, 1'b1, 32'h0000_0005, 32'h0000_0007, 1'b1); wait_done();
        issue(d, 1'b1, 32'h8000_0000, 32'h0000_0001, 1'b1); wait_done();
        issue(d, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0); wait_done();
        for (int i = 0; i < 4; i++) begin
            issue(d, 1'($urandom_range(1)), $urandom, $urandom, 1'($urandom_range(1)));
            wait_done();
        end
        // Result and flags hold after completion.
        repeat (3) @(negedge clk);
        checks++;
        if (res_v[d] !== last_exp.res || neg_v[d] !== last_exp.neg || zero_v[d] !== last_exp.zero) begin
            errors++;
            $display("FAIL hold dut=%0d got %h want %h", d, res_v[d], last_exp.res);
        end
    endtask

    task automatic test_ignore_start();
        issue(0, 1'b0, 32'h1234_0000, 32'h0000_5678, 1'b0);
        @(negedge clk);
        op = 1'b1; a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D; cin = 1'b1;
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        checks++;
        if (busy_v[0] !== 1'b1 || done_v[0] !== 1'b0) begin
            errors++;
            $display("FAIL busy_start got busy=%b done=%b want busy=1 done=0", busy_v[0], done_v[0]);
        end
        wait_done();
        repeat (6) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int n = 0;
        issue(0, 1'b0, 32'h0000_00FF, 32'h0000_0001, 1'b1);
        while (done_v[0] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done_v[0] !== 1'b1) begin
            errors++;
            $display("FAIL b2b_done got done=%b want 1", done_v[0]);
        end
        op = 1'b1; a = 32'h0000_0010; b = 32'h0000_0020; cin = 1'b1;
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        checks++;
        if (busy_v[0] !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept got busy=%b want 1", busy_v[0]);
        end
        sb.push_back(model(0, 1'b1, 32'h0000_0010, 32'h0000_0020, 1'b1, cyc));
        wait_done();
    endtask

    task automatic test_reset_abort();
        issue(0, 1'b0, 32'h0000_0001, 32'h0000_0002, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy_v[0] !== 1'b0 || res_v[0] !== 32'd0 || zero_v[0] !== 1'b1 || done_v[0] !== 1'b0) begin
            errors++;
            $display("FAIL abort got busy=%b res=%h zero=%b done=%b want 0 0 1 0",
                     busy_v[0], res_v[0], zero_v[0], done_v[0]);
        end
        sb.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        issue(0, 1'b1, 32'h0000_0064, 32'h0000_0019, 1'b1);
        wait_done();
    endtask

    initial begin
        for (int d = 0; d < 3; d++) start_v[d] = 1'b0;
        test_reset();
        for (int d = 0; d < 3; d++) test_vectors(d);
        test_ignore_start();
        test_back_to_back();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
